i2si_rx_fifo: RTL
=================

Name: i2si_rx_fifo

Overview:
Receive-side sample buffer for the I2S input path. Selects between the live deserializer and the BIST sawtooth generator output, then stores each completed 32-bit stereo word ({right[31:16], left[15:0]}) in a first-word-fall-through FIFO. The register file or DMA reads the FIFO through a pop handshake. Status includes level, overflow/underflow stickies and a threshold interrupt.

Parameters:
DEPTH, 8, number of 32-bit entries; power of two, 2..64
AW, 3, log2(DEPTH); pointer width

Ports:
clk  input  1  master clock
rst_n  input  1  synchronous active-low reset
rf_bist_en  input  1  1 = BIST source, 0 = deserializer source
i2si_rx_data  input  32  deserializer output word
i2si_rx_xfc  input  1  deserializer transfer-complete pulse (1 clk)
i2si_bist_out_data  input  32  BIST generator output word
i2si_bist_out_xfc  input  1  BIST transfer-complete pulse (1 clk)
rf_fifo_clr  input  1  synchronous flush pulse
rf_sts_clr  input  1  clears ovf/unf stickies
rf_fifo_thresh  input  AW+1  interrupt level threshold; 0 disables
fifo_rd_req  input  1  pop request
fifo_rd_data  output  32  head entry (FWFT); 0 when empty
fifo_empty  output  1  level == 0
fifo_full  output  1  level == DEPTH
fifo_level  output  AW+1  entries held, 0..DEPTH
fifo_ovf  output  1  sticky: push dropped while full
fifo_unf  output  1  sticky: pop requested while empty
i2si_irq  output  1  registered, level >= thresh && thresh != 0

Behaviour:
- Reset (rst_n low at posedge clk): pointers 0, level 0, empty 1, full 0, ovf 0, unf 0, irq 0, rd_data 0, src_sel register = 0. Memory contents are don't-care.
- Source mux: src_sel is a registered copy of rf_bist_en. push = src_sel ? i2si_bist_out_xfc : i2si_rx_xfc. wdata follows the same select.
- Source change: when rf_bist_en != src_sel, src_sel updates and the FIFO flushes exactly as on rf_fifo_clr. Any xfc in that cycle is discarded and stickies are untouched.
- Flush priority: rf_fifo_clr or source change > push/pop in the same cycle. Pointers and level go to 0. ovf/unf are unchanged.
- Push: on push && !full, write wdata at wr_ptr, increment wr_ptr (mod DEPTH). The word is visible on rd_data/level on the next cycle (1-clk latency).
- Push while full without a pop: the word is dropped, existing contents are kept, and fifo_ovf is set.
- Pop: on fifo_rd_req && !empty, rd_ptr increments and the next head appears the following cycle. rd_data is driven combinationally from mem[rd_ptr], gated to 0 when empty.
- Pop while empty: no pointer change, fifo_unf is set.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur, level unchanged.
  - Full: both occur, level stays DEPTH, no ovf.
  - Empty: push succeeds, pop counts as underflow (unf set), level becomes 1.
- Level arithmetic: level_next = level + push_ok - pop_ok. It never exceeds DEPTH and never wraps below 0. empty and full are decoded from the registered level.
- Stickies: set has priority over rf_sts_clr in the same cycle.
- Interrupt: i2si_irq registered from the post-update level, so it asserts 1 clk after the level crosses thresh. It deasserts 1 clk after the level drops below thresh, or when thresh is 0.
- Reset mid-operation: everything returns to reset values on the next posedge. Partial words are never stored.

Test Plan:
- Reset, rf_bist_en=0, push 3 rx words 0x0001FFFE/0x0002FFFD/0x0003FFFC -> level=3, rd_data=0x0001FFFE. Pop three times -> rd_data sequence 0x0002FFFD, 0x0003FFFC, then 0, empty=1.
- Fill 8 words (DEPTH=8), push a 9th (0xDEADBEEF) -> full=1, level=8, ovf=1, head unchanged, 0xDEADBEEF never read. Assert rf_sts_clr -> ovf=0.
- Full FIFO, push and pop in the same cycle -> level stays 8, ovf=0, last word written is read 8th.
- Empty FIFO, fifo_rd_req with a simultaneous push of 0x00A0FF5F -> unf=1, level=1, rd_data=0x00A0FF5F next cycle.
- Level=4, toggle rf_bist_en 0->1 with i2si_bist_out_xfc high in that cycle -> level=0 and that word is dropped. Subsequent BIST words 0x0100FEFF, 0x0110FEEF are stored in order.
- rf_fifo_thresh=2: push 2 words -> irq rises 1 clk after 2nd push. Pop 1 -> irq falls 1 clk later. Set thresh=0 -> irq=0.

Source files
------------

// File: rtl/i2si_rx_fifo_if.sv
// Pop/status bundle between the I2S receive FIFO (slave) and its reader,
// either the register file or DMA (master).
interface i2si_rx_fifo_if #(
    parameter int AW = 3
) ();
    logic          fifo_rd_req;
    logic [31:0]   fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_level;
    logic          fifo_ovf;
    logic          fifo_unf;
    logic          i2si_irq;

    modport master (
        output fifo_rd_req,
        input  fifo_rd_data, fifo_empty, fifo_full, fifo_level,
        input  fifo_ovf, fifo_unf, i2si_irq
    );

    modport slave (
        input  fifo_rd_req,
        output fifo_rd_data, fifo_empty, fifo_full, fifo_level,
        output fifo_ovf, fifo_unf, i2si_irq
    );
endinterface

// File: rtl/i2si_rx_fifo.sv
// I2S receive sample buffer: selects deserializer or BIST words and stores
// completed stereo words in a first-word-fall-through FIFO with status/irq.
module i2si_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rf_bist_en,
    input  logic [31:0]   i2si_rx_data,
    input  logic          i2si_rx_xfc,
    input  logic [31:0]   i2si_bist_out_data,
    input  logic          i2si_bist_out_xfc,
    input  logic          rf_fifo_clr,
    input  logic          rf_sts_clr,
    input  logic [AW:0]   rf_fifo_thresh,
    i2si_rx_fifo_if.slave rd_if
);

    localparam int          DATA_W   = 32;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_src_sel;
    logic              r_ovf;
    logic              r_unf;
    logic              r_irq;

    logic              w_src_chg;
    logic              w_flush;
    logic              w_push;
    logic [DATA_W-1:0] w_wdata;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [AW:0]       w_level_nxt;
    logic              w_irq_nxt;

    // A source switch behaves like a flush so samples from the two sources never mix.
    assign w_src_chg = (rf_bist_en != r_src_sel);
    assign w_flush   = rf_fifo_clr | w_src_chg;

    assign w_push  = r_src_sel ? i2si_bist_out_xfc  : i2si_rx_xfc;
    assign w_wdata = r_src_sel ? i2si_bist_out_data : i2si_rx_data;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    // When full, a concurrent pop frees the slot the push lands in.
    assign w_pop_ok  = !w_flush && rd_if.fifo_rd_req && !w_empty;
    assign w_push_ok = !w_flush && w_push && (!w_full || w_pop_ok);
    assign w_ovf_set = !w_flush && w_push && w_full && !w_pop_ok;
    assign w_unf_set = !w_flush && rd_if.fifo_rd_req && w_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_level_nxt = r_level + (AW+1)'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_level_nxt = r_level - (AW+1)'(1);
        end
    end

    assign w_irq_nxt = (rf_fifo_thresh != '0) && (w_level_nxt >= rf_fifo_thresh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src_sel <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_src_sel <= rf_bist_en;
            r_level   <= w_level_nxt;
            r_irq     <= w_irq_nxt;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Set wins over clear so an event coincident with the clear is not lost.
            if (w_ovf_set)       r_ovf <= 1'b1;
            else if (rf_sts_clr) r_ovf <= 1'b0;
            if (w_unf_set)       r_unf <= 1'b1;
            else if (rf_sts_clr) r_unf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_wdata;
    end

    assign rd_if.fifo_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_if.fifo_empty   = w_empty;
    assign rd_if.fifo_full    = w_full;
    assign rd_if.fifo_level   = r_level;
    assign rd_if.fifo_ovf     = r_ovf;
    assign rd_if.fifo_unf     = r_unf;
    assign rd_if.i2si_irq     = r_irq;

endmodule
